// File: rtl/br_resolve_pkg.sv
// Shared types for the branch resolution unit: per-instruction prediction
// metadata, the recovery FSM states and the misprediction test.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef struct packed {
      logic      valid;
      logic      is_br;
      rv32i_word pc;
      logic      pred_take;
      rv32i_word pred_target;
   } br_pkg_t;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } br_state_t;

   // A taken prediction is also wrong when the branch is taken to a different target
   function automatic logic is_mispred(input br_pkg_t p, input logic act_take,
                                       input rv32i_word act_target);
      return (p.pred_take != act_take) |
             (p.pred_take & act_take & (p.pred_target != act_target));
   endfunction

endpackage

// File: rtl/br_resolve_perf_cnt.sv
// Branch / misprediction performance counters, wrapping modulo 2**32.
// Only instantiated by br_resolve when BR_PERF_CNT_EN is defined.
module br_perf_cnt
   import rv32i_types::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      inc_br,
   input  logic      inc_mis,
   output rv32i_word br_cnt,
   output rv32i_word mispred_cnt
);

   rv32i_word br_cnt_r;
   rv32i_word mispred_cnt_r;

   // Count resolved branches and mispredictions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt_r      <= 32'd0;
         mispred_cnt_r <= 32'd0;
      end else begin
         if (inc_br) begin
            br_cnt_r <= br_cnt_r + 32'd1;
         end
         if (inc_mis) begin
            mispred_cnt_r <= mispred_cnt_r + 32'd1;
         end
      end
   end

   assign br_cnt      = br_cnt_r;
   assign mispred_cnt = mispred_cnt_r;

endmodule

// File: rtl/br_resolve.sv
// Branch resolution: carries IF predictions through ID/EX, checks them in EX,
// trains the predictor and drives flush/redirect. Optional macro: BR_PERF_CNT_EN.
module br_resolve
   import rv32i_types::*;
#(
   parameter int s_pc_offset = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      stall_id,
   input  logic      stall_ex,
   input  logic      if_valid,
   input  logic      if_is_br,
   input  rv32i_word if_pc,
   input  logic      pred_take,
   input  rv32i_word pred_target,
   input  logic      ex_br_en,
   input  rv32i_word ex_target,
   input  logic      redirect_ack,
   output logic      update,
   output logic      br_en,
   output logic      mispred,
   output logic      flush,
   output rv32i_word redirect_pc
`ifdef BR_PERF_CNT_EN
   ,
   output rv32i_word br_cnt,
   output rv32i_word mispred_cnt
`endif
);

   localparam rv32i_word pc_step = 32'd1 << s_pc_offset;

   br_state_t state_r;
   br_state_t next_state_s;
   br_pkg_t   id_r;
   br_pkg_t   ex_r;
   br_pkg_t   if_pkg_s;
   rv32i_word held_pc_r;
   rv32i_word correct_pc_s;
   rv32i_word redirect_pc_s;
   logic      resolve_s;
   logic      mispred_s;
   logic      flush_s;

   // Resolution of the branch currently leaving EX
   always_comb begin
      resolve_s    = ex_r.valid & ex_r.is_br & ~stall_ex & (state_r == RUN);
      mispred_s    = resolve_s & is_mispred(ex_r, ex_br_en, ex_target);
      correct_pc_s = ex_br_en ? ex_target : (ex_r.pc + pc_step);
   end

   // Recovery FSM next state and flush/redirect outputs
   always_comb begin
      next_state_s  = state_r;
      flush_s       = 1'b0;
      redirect_pc_s = 32'd0;
      case (state_r)
         RUN: begin
            if (mispred_s) begin
               flush_s       = 1'b1;
               redirect_pc_s = correct_pc_s;
               if (!redirect_ack) begin
                  next_state_s = HOLD;
               end else begin
                  next_state_s = RUN;
               end
            end else begin
               next_state_s = RUN;
            end
         end
         HOLD: begin
            flush_s       = 1'b1;
            redirect_pc_s = held_pc_r;
            if (redirect_ack) begin
               next_state_s = RUN;
            end else begin
               next_state_s = HOLD;
            end
         end
         default: begin
            next_state_s = RUN;
         end
      endcase
   end

   // IF metadata; nothing new is captured while a redirect is pending
   always_comb begin
      if_pkg_s.valid       = if_valid & (state_r == RUN) & ~flush_s;
      if_pkg_s.is_br       = if_is_br;
      if_pkg_s.pc          = if_pc;
      if_pkg_s.pred_take   = pred_take;
      if_pkg_s.pred_target = pred_target;
   end

   // FSM state and latched redirect target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= RUN;
         held_pc_r <= 32'd0;
      end else begin
         state_r <= next_state_s;
         if ((state_r == RUN) && mispred_s && !redirect_ack) begin
            held_pc_r <= correct_pc_s;
         end
      end
   end

   // ID/EX metadata pipeline; flush wins over both stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_r <= '0;
         ex_r <= '0;
      end else if (flush_s) begin
         id_r.valid <= 1'b0;
         ex_r.valid <= 1'b0;
      end else begin
         if (!stall_id) begin
            id_r <= if_pkg_s;
         end
         if (!stall_ex) begin
            if (stall_id) begin
               ex_r.valid <= 1'b0;
            end else begin
               ex_r <= id_r;
            end
         end
      end
   end

   assign update      = resolve_s;
   assign br_en       = ex_br_en;
   assign mispred     = mispred_s;
   assign flush       = flush_s;
   assign redirect_pc = redirect_pc_s;

`ifdef BR_PERF_CNT_EN
   br_perf_cnt u_perf_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_br      (resolve_s),
      .inc_mis     (mispred_s),
      .br_cnt      (br_cnt),
      .mispred_cnt (mispred_cnt)
   );
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Directed self-checking bench for br_resolve; counter checks are compiled
// in only when BR_PERF_CNT_EN is defined.
module tb_br_resolve;
   import rv32i_types::*;

   logic      clk = 1'b0;
   logic      rst;
   logic      stall_id, stall_ex, if_valid, if_is_br, pred_take;
   logic      ex_br_en, redirect_ack;
   rv32i_word if_pc, pred_target, ex_target;
   logic      update, br_en, mispred, flush;
   rv32i_word redirect_pc;
`ifdef BR_PERF_CNT_EN
   rv32i_word br_cnt, mispred_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   br_resolve #(.s_pc_offset(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_id     (stall_id),
      .stall_ex     (stall_ex),
      .if_valid     (if_valid),
      .if_is_br     (if_is_br),
      .if_pc        (if_pc),
      .pred_take    (pred_take),
      .pred_target  (pred_target),
      .ex_br_en     (ex_br_en),
      .ex_target    (ex_target),
      .redirect_ack (redirect_ack),
      .update       (update),
      .br_en        (br_en),
      .mispred      (mispred),
      .flush        (flush),
      .redirect_pc  (redirect_pc)
`ifdef BR_PERF_CNT_EN
      ,
      .br_cnt       (br_cnt),
      .mispred_cnt  (mispred_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_if(input logic v, input rv32i_word pc, input logic take, input rv32i_word tgt);
      if_valid    = v;
      if_is_br    = 1'b1;
      if_pc       = pc;
      pred_take   = take;
      pred_target = tgt;
   endtask

   task automatic set_ex(input logic take, input rv32i_word tgt, input logic ack);
      ex_br_en     = take;
      ex_target    = tgt;
      redirect_ack = ack;
   endtask

   // Put one branch in IF and advance it into EX (two unstalled edges)
   task automatic to_ex(input rv32i_word pc, input logic take, input rv32i_word tgt);
      set_if(1'b1, pc, take, tgt);
      tick();
      set_if(1'b0, 32'd0, 1'b0, 32'd0);
      tick();
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      set_if(1'b0, 32'd0, 1'b0, 32'd0);
      set_ex(1'b0, 32'd0, 1'b0);
      #12;
      chk("rst_update", {31'd0, update}, 32'd0);
      chk("rst_mispred", {31'd0, mispred}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_redirect", redirect_pc, 32'd0);
      rst = 1'b0;
      tick();

      // Correct not-taken prediction
      to_ex(32'h100, 1'b0, 32'd0);
      set_ex(1'b0, 32'd0, 1'b0);
      #1;
      chk("nt_update", {31'd0, update}, 32'd1);
      chk("nt_mispred", {31'd0, mispred}, 32'd0);
      chk("nt_flush", {31'd0, flush}, 32'd0);
      chk("nt_br_en", {31'd0, br_en}, 32'd0);
      tick();
      chk("nt_once", {31'd0, update}, 32'd0);

      // Not-taken predicted, taken actual, with a younger branch behind it
      set_if(1'b1, 32'h100, 1'b0, 32'd0);
      tick();
      set_if(1'b1, 32'h104, 1'b0, 32'd0);
      tick();
      set_if(1'b0, 32'd0, 1'b0, 32'd0);
      set_ex(1'b1, 32'h200, 1'b1);
      #1;
      chk("mp1_mispred", {31'd0, mispred}, 32'd1);
      chk("mp1_flush", {31'd0, flush}, 32'd1);
      chk("mp1_redirect", redirect_pc, 32'h200);
      chk("mp1_update", {31'd0, update}, 32'd1);
      chk("mp1_br_en", {31'd0, br_en}, 32'd1);
      tick();
      chk("mp1_squash_update", {31'd0, update}, 32'd0);
      chk("mp1_flush_single", {31'd0, flush}, 32'd0);
      tick();
      chk("mp1_squash2_update", {31'd0, update}, 32'd0);

      // Taken predicted to wrong target
      to_ex(32'h100, 1'b1, 32'h180);
      set_ex(1'b1, 32'h200, 1'b1);
      #1;
      chk("mp2_mispred", {31'd0, mispred}, 32'd1);
      chk("mp2_redirect", redirect_pc, 32'h200);
      tick();

      // Taken predicted, not taken actual: fall-through
      to_ex(32'h100, 1'b1, 32'h180);
      set_ex(1'b0, 32'h200, 1'b1);
      #1;
      chk("mp3_mispred", {31'd0, mispred}, 32'd1);
      chk("mp3_redirect", redirect_pc, 32'h104);
      tick();

      // Fall-through wraps at the top of the address space
      to_ex(32'hFFFF_FFFC, 1'b1, 32'h180);
      set_ex(1'b0, 32'h0, 1'b1);
      #1;
      chk("wrap_redirect", redirect_pc, 32'h0);
      tick();

      // Correct taken prediction
      to_ex(32'h300, 1'b1, 32'h400);
      set_ex(1'b1, 32'h400, 1'b0);
      #1;
      chk("tk_update", {31'd0, update}, 32'd1);
      chk("tk_mispred", {31'd0, mispred}, 32'd0);
      chk("tk_flush", {31'd0, flush}, 32'd0);
      tick();

      // Redirect held for three unacknowledged cycles
      to_ex(32'h100, 1'b0, 32'd0);
      set_ex(1'b1, 32'h200, 1'b0);
      #1;
      chk("hold_first_flush", {31'd0, flush}, 32'd1);
      chk("hold_first_redirect", redirect_pc, 32'h200);
      tick();
      ex_target = 32'h300;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) redirect_ack = 1'b1;
         #1;
         chk("hold_flush", {31'd0, flush}, 32'd1);
         chk("hold_redirect", redirect_pc, 32'h200);
         chk("hold_update", {31'd0, update}, 32'd0);
         tick();
      end
      chk("hold_exit_flush", {31'd0, flush}, 32'd0);
      set_ex(1'b0, 32'd0, 1'b0);

      // Stalled EX resolves exactly once
      do_reset();
      tick();
      to_ex(32'h500, 1'b0, 32'd0);
      stall_ex = 1'b1;
      stall_id = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_update", {31'd0, update}, 32'd0);
         tick();
      end
      stall_ex = 1'b0;
      stall_id = 1'b0;
      #1;
      chk("stall_release_update", {31'd0, update}, 32'd1);
      tick();
      chk("stall_after_update", {31'd0, update}, 32'd0);
`ifdef BR_PERF_CNT_EN
      chk("stall_br_cnt", br_cnt, 32'd1);
      chk("stall_mispred_cnt", mispred_cnt, 32'd0);
`endif

      // Stalled ID sends a bubble, then the branch follows
      set_if(1'b1, 32'h600, 1'b0, 32'd0);
      tick();
      set_if(1'b0, 32'd0, 1'b0, 32'd0);
      stall_id = 1'b1;
      tick();
      #1;
      chk("sid_bubble_update", {31'd0, update}, 32'd0);
      stall_id = 1'b0;
      tick();
      #1;
      chk("sid_late_update", {31'd0, update}, 32'd1);
      tick();

      // Asynchronous reset in HOLD
      to_ex(32'h100, 1'b0, 32'd0);
      set_ex(1'b1, 32'h200, 1'b0);
      tick();
      chk("arst_hold_flush", {31'd0, flush}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_flush", {31'd0, flush}, 32'd0);
      chk("arst_redirect", redirect_pc, 32'd0);
`ifdef BR_PERF_CNT_EN
      chk("arst_br_cnt", br_cnt, 32'd0);
      chk("arst_mispred_cnt", mispred_cnt, 32'd0);
`endif
      #1 rst = 1'b0;
      tick();
      chk("arst_after_flush", {31'd0, flush}, 32'd0);
      chk("arst_after_update", {31'd0, update}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/br_resolve.md
# br_resolve

Branch resolution unit: the consumer side of the local branch history predictor. Captures each IF-stage prediction (direction and target), carries it through ID and EX under the pipeline's stall rules, compares it against the actual outcome computed in EX, and drives the predictor's `update`/`br_en` training inputs plus the pipeline `flush`/`redirect_pc` recovery path. A two-state recovery FSM holds the redirect until fetch accepts it.

## Interface
Parameters:
- `s_pc_offset`, 2: byte offset of sequential PC step (fall-through = pc + 2**s_pc_offset).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_id`  in  1  ID stage holds.
- `stall_ex`  in  1  EX stage holds.
- `if_valid`  in  1  IF holds a real instruction.
- `if_is_br`  in  1  IF instruction is a conditional branch.
- `if_pc`  in  32  IF instruction PC (`rv32i_word`).
- `pred_take`  in  1  predictor direction for IF instruction.
- `pred_target`  in  32  predicted target, meaningful when `pred_take`=1.
- `ex_br_en`  in  1  actual branch outcome in EX.
- `ex_target`  in  32  actual branch target in EX.
- `redirect_ack`  in  1  fetch accepts `redirect_pc` this cycle.
- `update`  out  1  train predictor this cycle.
- `br_en`  out  1  actual outcome to predictor (= `ex_br_en`).
- `mispred`  out  1  misprediction resolved this cycle.
- `flush`  out  1  squash IF/ID/EX younger instructions.
- `redirect_pc`  out  32  correct next PC while `flush`=1.
- `br_cnt`, `mispred_cnt`  out  32  perf counters (only with `BR_PERF_CNT_EN`).

## Operation
- Metadata pkg {valid, is_br, pc, pred_take, pred_target}; IF pkg built combinationally, valid = `if_valid` & state==RUN & !`flush`.
- ID reg: hold if `stall_id`, else load IF pkg. EX reg: hold if `stall_ex`; else load ID pkg, or bubble (valid=0) if `stall_id`.
- `flush`=1 clears valid in ID and EX at next edge; flush overrides stalls.
- Resolve when EX valid & is_br & !`stall_ex` & state==RUN: `update`=1.
- `mispred` = resolve & ((pred_take != ex_br_en) | (pred_take & ex_br_en & pred_target != ex_target)).
- Correct PC = `ex_br_en` ? `ex_target` : pc + 2**s_pc_offset (32-bit, wraps).
- FSM RUN: `mispred` → `flush`=1, `redirect_pc` = correct PC (combinational); if !`redirect_ack` latch PC, go HOLD; else stay RUN.
- FSM HOLD: `flush`=1, `redirect_pc` = latched PC, no resolution, no IF capture; `redirect_ack` → RUN.
- Non-branch or invalid EX: `update`=`mispred`=0.

## Timing
- Reset (async): state RUN, ID/EX valid 0, latched PC 0, counters 0; all outputs 0.
- `update`/`mispred`/`flush` combinational in the resolving EX cycle; predictor writes at that edge.
- IF prediction reaches EX after 2 unstalled edges.
- Stalled EX never re-resolves: `update` asserts at most once per branch (only on the cycle EX advances).
- `mispred` & `redirect_ack` same cycle: single-cycle flush, stay RUN.
- Reset asserted in HOLD: immediate RUN, `flush` drops asynchronously.

## Configuration
- `BR_PERF_CNT_EN` defined: `br_cnt` += 1 per `update`, `mispred_cnt` += 1 per `mispred`; both wrap modulo 2**32.
- Undefined: counter ports and logic absent; behaviour otherwise identical.

## Structure
- `rv32i_types`: `br_pkg_t` struct, `br_state_t` enum {RUN, HOLD}.
- Sub-module `br_perf_cnt` (two counters with increment enables), instantiated only under `BR_PERF_CNT_EN`.

## Test plan
- Branch at pc 0x100, pred_take=0, ex_br_en=0, no stalls → 2 edges later `update`=1, `mispred`=0, `flush`=0.
- pc 0x100, pred_take=0, ex_br_en=1, ex_target=0x200, redirect_ack=1 → `mispred`=`flush`=1, `redirect_pc`=0x200, ID/EX valid 0 next cycle.
- pred_take=1, pred_target=0x180, ex_br_en=1, ex_target=0x200 → `mispred`=1; pred_take=1, ex_br_en=0 → `redirect_pc`=0x104.
- Mispredict with redirect_ack=0 for 3 cycles → `flush` high 4 cycles, `redirect_pc` stable, no `update`; ack → RUN.
- `stall_ex`=1 for 3 cycles on resolving branch → exactly one `update` pulse when stall drops; `br_cnt`=1.
- Async `rst` pulse mid-HOLD (between edges) → `flush`=0 immediately, counters 0.
